fetch_unit: RTL

- IF-stage block for the 5-stage pipeline: owns the PC, issues instruction-memory requests over a req/ack handshake, and drives the IF/ID pipeline register.
- Consumes the hazard unit's load-use stall and the ID stage's branch flush, and produces the instruction stream that the hazard unit and decoder observe.
- Replaces the free-running PC register and bare IF/ID register, so multi-cycle instruction memory is supported.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/if_id_reg.sv | 31 +++
 rtl/fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants.
package cpu_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam int PC_INC = 4;
  localparam logic [INST_W_DEF-1:0] NOP_INST = '0;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble wins over load, otherwise holds.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [INST_W-1:0] inst_d,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              valid
);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      pc    <= '0;
      inst  <= INST_W'(NOP_INST);
      valid <= 1'b0;
    end else if (bubble) begin
      inst  <= INST_W'(NOP_INST);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_d;
      inst  <= inst_d;
      valid <= 1'b1;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with PC, req/ack imem handshake, skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/bubble counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic [INST_W-1:0] if_id_inst_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic              if_id_valid_o
);
  fetch_state_e state, state_nx;
  logic [ADDR_W-1:0] pc, skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic skid_vld, active, fl, take, ld_mem, to_skid, ld_skid, bub;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start_i ? FETCH : IDLE;
    else if (fl || ld_skid) state_nx = FETCH;
    else if (to_skid) state_nx = HOLD;
  end

  // Flush dominates every other action once fetching has started
  always_comb begin
    imem_req_o = state == FETCH;
    active     = state != IDLE;
    fl         = active && flush_i;
    take       = imem_req_o && imem_ack_i;
    ld_mem     = !fl && take && !stall_i;
    to_skid    = !fl && take && stall_i;
    ld_skid    = !fl && state == HOLD && skid_vld && !stall_i;
    bub        = fl || (imem_req_o && !imem_ack_i && !stall_i);
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      pc        <= RESET_PC;
      skid_pc   <= '0;
      skid_inst <= '0;
      skid_vld  <= 1'b0;
    end else begin
      pc        <= fl ? {branch_target_i[ADDR_W-1:2], 2'b00} :
                   (ld_mem || ld_skid) ? pc + ADDR_W'(PC_INC) : pc;
      skid_pc   <= to_skid ? pc : skid_pc;
      skid_inst <= to_skid ? imem_data_i : skid_inst;
      skid_vld  <= to_skid ? 1'b1 : (fl || ld_skid) ? 1'b0 : skid_vld;
    end

  assign imem_addr_o = pc;

  if_id_reg #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_if_id (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (ld_mem || ld_skid),
    .bubble (bub),
    .pc_d   (ld_skid ? skid_pc : pc),
    .inst_d (ld_skid ? skid_inst : imem_data_i),
    .pc     (if_id_pc_o),
    .inst   (if_id_inst_o),
    .valid  (if_id_valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      stall_cnt_o  <= (active && stall_i && ~&stall_cnt_o) ? stall_cnt_o + 32'd1 : stall_cnt_o;
      bubble_cnt_o <= (bub && ~&bubble_cnt_o) ? bubble_cnt_o + 32'd1 : bubble_cnt_o;
    end
`endif
endmodule
